// File: rtl/ball_physics.sv
// ball_physics: per-frame ball motion and collision engine for Breakout.
// Each accepted frame tick launches a fixed scan: STEP computes the next
// position, WALL clamps/bounces off the screen edges, PADDLE resolves the
// paddle, and BRICK walks the 24 bricks one per cycle. COMMIT then publishes
// the new position. Falling past the bottom edge costs a life.
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   frame_tick   one-cycle pulse at start of vertical blanking
//   launch       level, releases the held ball (IDLE only)
//   paddle_x     paddle left edge, sampled in PADDLE
//   ball_x/y     ball top-left corner
//   brick_alive  bit i = brick i present, i = row*8 + col
//   score        bricks destroyed, saturating
//   lives        remaining lives
//   game_over    high once the game has ended
//   busy         high while a frame is being processed
module ball_physics #(
    parameter int   SCREEN_W  = 640,
    parameter int   SCREEN_H  = 480,
    parameter int   BALL_SIZE = 5,
    parameter int   SPEED     = 2,
    parameter int   BALL_X0   = 300,
    parameter int   BALL_Y0   = 300,
    parameter logic DX0       = 1'b1,
    parameter logic DY0       = 1'b0,
    parameter int   PADDLE_Y  = 440,
    parameter int   PADDLE_W  = 160,
    parameter int   PADDLE_H  = 20,
    parameter int   BRICK_W   = 80,
    parameter int   BRICK_H   = 30,
    parameter int   BRICK_Y0  = 20,
    parameter int   ROW_PITCH = 50,
    parameter int   LIVES0    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        launch,
    input  logic [9:0]  paddle_x,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic [23:0] brick_alive,
    output logic [7:0]  score,
    output logic [1:0]  lives,
    output logic        game_over,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, WAIT, STEP, WALL, PADDLE, BRICK, COMMIT, LOST, DONE
    } state_t;

    localparam int X_MAX = SCREEN_W - BALL_SIZE;
    localparam int Y_MAX = SCREEN_H - BALL_SIZE;

    state_t             state;
    logic signed [10:0] nx, ny;     // candidate position, may go negative
    logic               dx, dy;
    logic [4:0]         idx;        // brick under test, row = idx[4:3], col = idx[2:0]

    int   nx_i, ny_i, px_i, brick_x, brick_y;
    logic paddle_hit, brick_hit;

    // Overlap tests are half-open on both axes, so touching edges miss.
    always_comb begin
        nx_i    = int'(nx);
        ny_i    = int'(ny);
        px_i    = int'(paddle_x);
        brick_x = int'(idx[2:0]) * BRICK_W;
        brick_y = BRICK_Y0 + int'(idx[4:3]) * ROW_PITCH;
        paddle_hit = dy &&
                     (nx_i < px_i + PADDLE_W) && (px_i < nx_i + BALL_SIZE) &&
                     (ny_i < PADDLE_Y + PADDLE_H) && (PADDLE_Y < ny_i + BALL_SIZE);
        brick_hit  = brick_alive[idx] &&
                     (nx_i < brick_x + BRICK_W) && (brick_x < nx_i + BALL_SIZE) &&
                     (ny_i < brick_y + BRICK_H) && (brick_y < ny_i + BALL_SIZE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ball_x      <= 10'(BALL_X0);
            ball_y      <= 10'(BALL_Y0);
            dx          <= DX0;
            dy          <= DY0;
            nx          <= '0;
            ny          <= '0;
            idx         <= '0;
            brick_alive <= 24'hFFFFFF;
            score       <= '0;
            lives       <= 2'(LIVES0);
            game_over   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (launch) state <= WAIT;
                WAIT: if (frame_tick) begin
                    state <= STEP;
                    busy  <= 1'b1;
                end
                STEP: begin
                    nx    <= 11'(int'(ball_x) + (dx ? SPEED : -SPEED));
                    ny    <= 11'(int'(ball_y) + (dy ? SPEED : -SPEED));
                    state <= WALL;
                end
                WALL: begin
                    if (nx_i <= 0) begin
                        nx <= '0;
                        dx <= 1'b1;
                    end else if (nx_i >= X_MAX) begin
                        nx <= 11'(X_MAX);
                        dx <= 1'b0;
                    end
                    if (ny_i >= Y_MAX) begin
                        state <= LOST;
                    end else begin
                        if (ny_i <= 0) begin
                            ny <= '0;
                            dy <= 1'b1;
                        end
                        state <= PADDLE;
                    end
                end
                PADDLE: begin
                    // Rest the ball on the paddle top; direction from which half was hit.
                    if (paddle_hit) begin
                        ny <= 11'(PADDLE_Y - BALL_SIZE);
                        dy <= 1'b0;
                        dx <= !(nx_i + BALL_SIZE / 2 < px_i + PADDLE_W / 2);
                    end
                    idx   <= '0;
                    state <= BRICK;
                end
                BRICK: begin
                    if (brick_hit) begin
                        brick_alive[idx] <= 1'b0;
                        if (score != 8'hFF) score <= score + 8'd1;
                        dy    <= ~dy;
                        state <= COMMIT;
                    end else if (idx == 5'd23) begin
                        state <= COMMIT;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                COMMIT: begin
                    ball_x <= nx[9:0];
                    ball_y <= ny[9:0];
                    busy   <= 1'b0;
                    if (brick_alive == '0) begin
                        game_over <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= WAIT;
                    end
                end
                LOST: begin
                    lives <= lives - 2'd1;
                    busy  <= 1'b0;
                    if (lives == 2'd1) begin
                        // Ball stays frozen where it was last drawn.
                        game_over <= 1'b1;
                        state     <= DONE;
                    end else begin
                        ball_x <= 10'(BALL_X0);
                        ball_y <= 10'(BALL_Y0);
                        dx     <= DX0;
                        dy     <= DY0;
                        state  <= IDLE;
                    end
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_physics.sv
// Bench for ball_physics: six instances with different spawn settings share
// the inputs; a frame-level reference model predicts each one's outputs.
module tb_ball_physics;
    localparam int N = 6;
    localparam int P_X0  [N] = '{300, 634, 10, 300, 210, 300};
    localparam int P_Y0  [N] = '{300, 300, 51, 434, 434, 474};
    localparam int P_DY0 [N] = '{0, 0, 0, 1, 1, 1};

    logic       clk = 1'b0, rst = 1'b0, frame_tick = 1'b0, launch = 1'b0;
    logic [9:0] paddle_x = '0;

    logic [9:0]  bx [N];
    logic [9:0]  by [N];
    logic [23:0] alive [N];
    logic [7:0]  score [N];
    logic [1:0]  lives [N];
    logic        go [N];
    logic        busy [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        ball_physics #(
            .BALL_X0(P_X0[g]),
            .BALL_Y0(P_Y0[g]),
            .DY0(P_DY0[g] != 0)
        ) u_dut (
            .clk(clk), .rst(rst), .frame_tick(frame_tick), .launch(launch),
            .paddle_x(paddle_x), .ball_x(bx[g]), .ball_y(by[g]),
            .brick_alive(alive[g]), .score(score[g]), .lives(lives[g]),
            .game_over(go[g]), .busy(busy[g])
        );
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: mode 0 = held, 1 = armed, 2 = game over.
    int          mx [N], my [N], mdx [N], mdy [N], mscore [N], mlives [N], mgo [N], mmode [N];
    logic [23:0] malive [N];

    task automatic model_reset();
        for (int g = 0; g < N; g++) begin
            mx[g] = P_X0[g]; my[g] = P_Y0[g]; mdx[g] = 1; mdy[g] = P_DY0[g];
            malive[g] = 24'hFFFFFF; mscore[g] = 0; mlives[g] = 3; mgo[g] = 0; mmode[g] = 0;
        end
    endtask

    function automatic bit ovl(int ax, int ay, int rx, int ry, int rw, int rh);
        return (ax < rx + rw) && (rx < ax + 5) && (ay < ry + rh) && (ry < ay + 5);
    endfunction

    task automatic model_frame(input int g, input int px);
        int nx, ny;
        bit hit;
        nx = mx[g] + (mdx[g] != 0 ? 2 : -2);
        ny = my[g] + (mdy[g] != 0 ? 2 : -2);
        if (nx <= 0) begin nx = 0; mdx[g] = 1; end
        if (nx >= 635) begin nx = 635; mdx[g] = 0; end
        if (ny >= 475) begin
            mlives[g]--;
            if (mlives[g] == 0) begin
                mgo[g] = 1; mmode[g] = 2;
            end else begin
                mx[g] = P_X0[g]; my[g] = P_Y0[g]; mdx[g] = 1; mdy[g] = P_DY0[g]; mmode[g] = 0;
            end
            return;
        end
        if (ny <= 0) begin ny = 0; mdy[g] = 1; end
        if (mdy[g] != 0 && ovl(nx, ny, px, 440, 160, 20)) begin
            ny = 435; mdy[g] = 0;
            mdx[g] = (nx + 2 < px + 80) ? 0 : 1;
        end
        hit = 0;
        for (int i = 0; i < 24; i++) begin
            if (!hit && malive[g][i] && ovl(nx, ny, (i % 8) * 80, 20 + (i / 8) * 50, 80, 30)) begin
                hit = 1;
                malive[g][i] = 1'b0;
                if (mscore[g] < 255) mscore[g]++;
                mdy[g] = 1 - mdy[g];
            end
        end
        mx[g] = nx; my[g] = ny;
        if (malive[g] == 0) begin mgo[g] = 1; mmode[g] = 2; end
    endtask

    task automatic check_all(input string tag);
        for (int g = 0; g < N; g++) begin
            chk($sformatf("%s.x%0d", tag, g), int'(bx[g]), mx[g]);
            chk($sformatf("%s.y%0d", tag, g), int'(by[g]), my[g]);
            chk($sformatf("%s.alive%0d", tag, g), int'(alive[g]), int'(malive[g]));
            chk($sformatf("%s.score%0d", tag, g), int'(score[g]), mscore[g]);
            chk($sformatf("%s.lives%0d", tag, g), int'(lives[g]), mlives[g]);
            chk($sformatf("%s.go%0d", tag, g), int'(go[g]), mgo[g]);
            chk($sformatf("%s.busy%0d", tag, g), int'(busy[g]), 0);
        end
    endtask

    // Tick, then run 32 cycles; k counts cycles after the tick cycle.
    task automatic run_frame(input bit timing, input bit extra);
        @(posedge clk); #1; frame_tick = 1'b1;
        @(posedge clk); #1; frame_tick = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (timing) begin
                if (k <= 29) chk($sformatf("busy_k%0d", k), int'(busy[0]), (k <= 28) ? 1 : 0);
                if (k == 28) chk("pos_k28", int'(by[0]), 300);
                if (k == 29) chk("posx_k29", int'(bx[0]), 302);
                if (k == 29) chk("posy_k29", int'(by[0]), 298);
                if (k == 5) chk("brk_k5", int'(by[2]), 51);
                if (k == 6) chk("brk_k6", int'(by[2]), 49);
            end
            if (extra && k == 2) frame_tick = 1'b1;   // dropped: all instances busy
            if (extra && k == 3) frame_tick = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bit directed;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("rst");
        rst = 1'b1;
        for (int game = 0; game < 3; game++) begin
            for (int f = 0; f < 120; f++) begin
                directed = (game == 0 && f < 3);
                paddle_x = directed ? 10'd200 : 10'($urandom_range(0, 600));
                launch   = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
                repeat (2) @(posedge clk);
                #1;
                for (int g = 0; g < N; g++) if (mmode[g] == 0 && launch) mmode[g] = 1;
                for (int g = 0; g < N; g++) if (mmode[g] == 1) model_frame(g, int'(paddle_x));
                run_frame(game == 0 && f == 0, !directed && $urandom_range(0, 3) == 0);
                for (int g = 0; g < N; g++) if (mmode[g] == 0 && launch) mmode[g] = 1;
                check_all($sformatf("g%0df%0d", game, f));
                if (game == 0 && f == 0) begin
                    chk("wall_clamp", int'(bx[1]), 635);
                    chk("brick_x", int'(bx[2]), 12);
                    chk("brick_y", int'(by[2]), 49);
                    chk("brick_mask", int'(alive[2]), 24'hFFFFFE);
                    chk("brick_score", int'(score[2]), 1);
                    chk("paddle_y", int'(by[3]), 435);
                    chk("lost_lives", int'(lives[5]), 2);
                    chk("lost_respawn", int'(by[5]), 474);
                end
                if (game == 0 && f == 1) begin
                    chk("wall_back", int'(bx[1]), 633);
                    chk("brick_bounce", int'(by[2]), 51);
                    chk("paddle_dx1", int'(bx[3]), 304);
                    chk("paddle_dx0", int'(bx[4]), 210);
                end
                if (game == 0 && f == 2) begin
                    chk("lost_zero", int'(lives[5]), 0);
                    chk("lost_go", int'(go[5]), 1);
                end
            end
            rst = 1'b0;
            #1;
            model_reset();
            check_all($sformatf("rst%0d", game));
            @(posedge clk); #1;
            rst = 1'b1;
        end

        // Asynchronous reset in the middle of a scan.
        launch = 1'b1;
        paddle_x = 10'd200;
        repeat (2) @(posedge clk);
        #1;
        @(posedge clk); #1; frame_tick = 1'b1;
        @(posedge clk); #1; frame_tick = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        chk("mid_busy", int'(busy[0]), 1);
        chk("mid_brick", int'(alive[2]), 24'hFFFFFE);
        rst = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        #10;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
